// File: rtl/serial_alu_w.sv
// ---------------------------------------------------------------------------
// serial_alu_w
//
// Parametrised bit-serial ALU. Operands are latched on an accepted start and
// processed one bit per clock, LSB first. The result register C and the
// ZF/SF/CF (and optional OF) flags change only when an operation completes,
// so a consumer never sees a partial result.
//
// Opcodes: 000 CLR, 001 NAND, 010 ADD, 011 OR, 100 SUB (A-B), 101 AND,
//          110 XOR, 111 ADC (A+B+CF).
//
// Optional feature: define SERIAL_ALU_OVF_EN to add the OF port and the
// signed-overflow logic. Without it there is no OF port and no OF logic.
//
// Ports:
//   clk     in   1      clock, rising edge
//   rst_n   in   1      synchronous reset, active low
//   start   in   1      request, sampled only while busy=0
//   opcode  in   3      operation, latched with start
//   A, B    in   WIDTH  operands, latched with start
//   busy    out  1      operation in progress (bit-serial phase)
//   done    out  1      one-cycle pulse in the cycle C/flags are updated
//   C       out  WIDTH  result register
//   ZF/SF/CF out 1      zero, sign and carry/borrow flags
//   OF      out  1      signed overflow (SERIAL_ALU_OVF_EN only)
// ---------------------------------------------------------------------------
module serial_alu_w #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C,
    output logic             ZF,
    output logic             SF,
    output logic             CF
`ifdef SERIAL_ALU_OVF_EN
    ,
    output logic             OF
`endif
);

    localparam int             IW   = $clog2(WIDTH);
    localparam logic [IW-1:0]  LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        OP_CLR  = 3'b000,
        OP_NAND = 3'b001,
        OP_ADD  = 3'b010,
        OP_OR   = 3'b011,
        OP_SUB  = 3'b100,
        OP_AND  = 3'b101,
        OP_XOR  = 3'b110,
        OP_ADC  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_e;

    state_e           state, state_nx;
    logic             accept;

    // Shadow copies of the request; A/B may change freely after start.
    logic [WIDTH-1:0] a_sh, b_sh;
    op_e              op_sh;
    // Result bits computed so far; the bit of the current step is prepended
    // combinationally, so only WIDTH-1 bits need storing.
    logic [WIDTH-2:0] res_sh;
    logic [IW-1:0]    idx;
    logic             carry;

    logic             is_sub, is_arith;
    logic             b_eff, sum_bit, cout, res_bit;
    logic [WIDTH-1:0] res_full;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs. A request is accepted in IDLE and also in
    // FIN: the previous result is already committed by then, which gives
    // back-to-back operation without an idle gap.
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        case (state)
            S_IDLE, S_FIN: begin
                done = (state == S_FIN);
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (opcode == OP_CLR) ? S_FIN : S_RUN;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (idx == LAST) state_nx = S_FIN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // One-bit datapath. SUB is A + ~B + 1: B is inverted per bit and the
    // carry is preset to 1 at start.
    // ------------------------------------------------------------------
    always_comb begin
        is_sub   = (op_sh == OP_SUB);
        is_arith = (op_sh == OP_ADD) || (op_sh == OP_ADC) || (op_sh == OP_SUB);
        b_eff    = b_sh[0] ^ is_sub;
        sum_bit  = a_sh[0] ^ b_eff ^ carry;
        cout     = (a_sh[0] & b_eff) | (a_sh[0] & carry) | (b_eff & carry);
        case (op_sh)
            OP_NAND: res_bit = ~(a_sh[0] & b_sh[0]);
            OP_OR:   res_bit = a_sh[0] | b_sh[0];
            OP_AND:  res_bit = a_sh[0] & b_sh[0];
            OP_XOR:  res_bit = a_sh[0] ^ b_sh[0];
            default: res_bit = sum_bit;
        endcase
        res_full = {res_bit, res_sh};
    end

    // ------------------------------------------------------------------
    // Shadow registers, serial carry and committed outputs.
    // The last bit is committed on the same edge it is computed, so C and
    // the flags are visible in the FIN (done) cycle.
    // ------------------------------------------------------------------
    // NOTE: the shadow registers are reset too, not just the visible
    // outputs, so no stale operand or carry survives an aborted operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            op_sh  <= OP_CLR;
            res_sh <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            C      <= '0;
            ZF     <= 1'b0;
            SF     <= 1'b0;
            CF     <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            OF     <= 1'b0;
`endif
        end else if (accept) begin
            a_sh   <= A;
            b_sh   <= B;
            op_sh  <= op_e'(opcode);
            res_sh <= '0;
            idx    <= '0;
            // ADC takes the CF visible now, which in a FIN cycle is the
            // value committed by the operation just finishing.
            carry  <= (opcode == OP_SUB) | ((opcode == OP_ADC) & CF);
            if (opcode == OP_CLR) begin
                C  <= '0;
                ZF <= 1'b0;
                SF <= 1'b0;
                CF <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
                OF <= 1'b0;
`endif
            end
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_full[WIDTH-1:1];
            carry  <= cout;
            idx    <= idx + 1'b1;
            if (idx == LAST) begin
                C  <= res_full;
                ZF <= (res_full == '0);
                SF <= res_full[WIDTH-1];
                // Borrow is the inverted carry for SUB; logic ops keep CF.
                if (is_arith) CF <= cout ^ is_sub;
`ifdef SERIAL_ALU_OVF_EN
                // carry holds the carry into the MSB at this step.
                OF <= is_arith & (carry ^ cout);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_w.sv
// ---------------------------------------------------------------------------
// tb_serial_alu_w
//
// Directed bench for serial_alu_w (WIDTH=8). Expected results come from a
// word-level reference model and are queued when an operation is issued,
// then popped and compared when done is seen. Outputs are sampled on the
// falling edge; inputs are driven on the falling edge as well.
// OF checks are compiled in only when SERIAL_ALU_OVF_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_alu_w;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   opcode;
    logic [W-1:0] A, B;
    logic         busy, done;
    logic [W-1:0] C;
    logic         ZF, SF, CF;
`ifdef SERIAL_ALU_OVF_EN
    logic         OF;
`endif

    always #5 clk = ~clk;

    serial_alu_w #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .opcode (opcode),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .C      (C),
        .ZF     (ZF),
        .SF     (SF),
        .CF     (CF)
`ifdef SERIAL_ALU_OVF_EN
        ,
        .OF     (OF)
`endif
    );

    typedef struct {
        logic [W-1:0] c;
        logic         zf, sf, cf, of;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic m_cf;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference model.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cf_in);
        exp_t       e;
        logic [W:0] s;
        e.c   = '0;
        e.cf  = cf_in;
        e.of  = 1'b0;
        e.lat = W + 1;
        case (op)
            3'b000: begin e.cf = 1'b0; e.lat = 1; end
            3'b001: e.c = ~(a & b);
            3'b011: e.c = a | b;
            3'b101: e.c = a & b;
            3'b110: e.c = a ^ b;
            3'b100: begin
                e.c  = a - b;
                e.cf = (a < b);
                e.of = (a[W-1] != b[W-1]) && (e.c[W-1] != a[W-1]);
            end
            default: begin
                s    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (op == 3'b111) ? cf_in : 1'b0};
                e.c  = s[W-1:0];
                e.cf = s[W];
                e.of = (a[W-1] == b[W-1]) && (e.c[W-1] != a[W-1]);
            end
        endcase
        e.zf = (op == 3'b000) ? 1'b0 : (e.c == '0);
        e.sf = e.c[W-1];
        return e;
    endfunction

    // Drive one request at a falling edge; it is sampled at the next rising
    // edge, after which the inputs are scrambled.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e    = model(op, a, b, m_cf);
        m_cf = e.cf;
        sb.push_back(e);
        start  = 1'b1;
        opcode = op;
        A      = a;
        B      = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        opcode = 3'($urandom);
        A      = W'($urandom);
        B      = W'($urandom);
    endtask

    // Wait for done (bounded), checking that C/flags hold while running.
    // poke>0 presents an extra start in that running cycle.
    task automatic wait_done(input string tag, input int poke);
        exp_t e;
        int   n;
        int   busy_cnt;
        logic got;
        busy_cnt = 0;
        got      = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            check({tag, " hold"}, {53'b0, C, ZF, SF, CF}, {53'b0, cur.c, cur.zf, cur.sf, cur.cf});
            if (busy) busy_cnt++;
            if (poke > 0 && n == poke) begin
                start  = 1'b1;
                opcode = 3'b100;
                A      = 8'hFF;
                B      = 8'hFF;
            end
            if (poke > 0 && n == poke + 1) start = 1'b0;
        end
        check({tag, " done seen"}, {63'b0, got}, 64'd1);
        if (got) begin
            e = sb.pop_front();
            check({tag, " latency"}, 64'(n), 64'(e.lat));
            check({tag, " C"}, {56'b0, C}, {56'b0, e.c});
            check({tag, " ZF"}, {63'b0, ZF}, {63'b0, e.zf});
            check({tag, " SF"}, {63'b0, SF}, {63'b0, e.sf});
            check({tag, " CF"}, {63'b0, CF}, {63'b0, e.cf});
`ifdef SERIAL_ALU_OVF_EN
            check({tag, " OF"}, {63'b0, OF}, {63'b0, e.of});
`endif
            check({tag, " busy in done"}, {63'b0, busy}, 64'd0);
            if (e.lat > 1) check({tag, " busy cycles"}, 64'(busy_cnt), 64'(W));
            cur = e;
        end
    endtask

    initial begin
        logic saw_done;
        rst_n  = 1'b0;
        start  = 1'b0;
        opcode = 3'b000;
        A      = '0;
        B      = '0;
        m_cf   = 1'b0;
        cur    = '{c: '0, zf: 1'b0, sf: 1'b0, cf: 1'b0, of: 1'b0, lat: 0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", {63'b0, busy}, 64'd0);
        check("rst done", {63'b0, done}, 64'd0);
        check("rst C", {56'b0, C}, 64'd0);
        check("rst flags", {61'b0, ZF, SF, CF}, 64'd0);
`ifdef SERIAL_ALU_OVF_EN
        check("rst OF", {63'b0, OF}, 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Carry out of the MSB, zero result
        issue(3'b010, 8'hFF, 8'h01);  wait_done("add_ff_01", 0);
        @(negedge clk);

        // Borrow, then back-to-back SUB issued in the done cycle
        issue(3'b100, 8'h05, 8'h07);  wait_done("sub_05_07", 0);
        issue(3'b100, 8'h07, 8'h05);  wait_done("sub_07_05", 0);

        // ADD with carry, ADC consuming it, logic op keeping CF, CLR
        issue(3'b010, 8'hF0, 8'h20);  wait_done("add_f0_20", 0);
        issue(3'b111, 8'h00, 8'h00);  wait_done("adc_00_00", 0);
        issue(3'b001, 8'hFF, 8'hFF);  wait_done("nand_ff_ff", 0);
        issue(3'b000, 8'h00, 8'h00);  wait_done("clr", 0);
        @(negedge clk);

        // start during busy is ignored
        issue(3'b010, 8'h11, 8'h22);  wait_done("add_busy_poke", 2);
        @(negedge clk);

        // Signed overflow cases (OF compared only when the feature is built)
        issue(3'b010, 8'h7F, 8'h01);  wait_done("add_7f_01", 0);
        issue(3'b100, 8'h80, 8'h01);  wait_done("sub_80_01", 0);
        issue(3'b101, 8'hC3, 8'h5A);  wait_done("and_c3_5a", 0);
        issue(3'b011, 8'h00, 8'h00);  wait_done("or_zero", 0);
        issue(3'b010, 8'h90, 8'h90);  wait_done("add_90_90", 0);
        issue(3'b110, 8'h5A, 8'h0F);  wait_done("xor_5a_0f", 0);
        @(negedge clk);

        // Reset in the middle of an operation
        issue(3'b010, 8'h12, 8'h34);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort done", {63'b0, done}, 64'd0);
        check("abort busy", {63'b0, busy}, 64'd0);
        check("abort C", {56'b0, C}, 64'd0);
        check("abort flags", {61'b0, ZF, SF, CF}, 64'd0);
`ifdef SERIAL_ALU_OVF_EN
        check("abort OF", {63'b0, OF}, 64'd0);
`endif
        rst_n = 1'b1;
        sb.delete();
        m_cf = 1'b0;
        cur  = '{c: '0, zf: 1'b0, sf: 1'b0, cf: 1'b0, of: 1'b0, lat: 0};
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort no done", {63'b0, saw_done}, 64'd0);

        // Normal operation after the abort
        issue(3'b010, 8'h01, 8'h02);  wait_done("add_after_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_alu_w.md
# serial_alu_w

Parametrised bit-serial ALU, successor to the 4-bit serial ALU. It accepts WIDTH-bit operands with a start/busy/done handshake and processes one bit per clock, LSB first. The result and the ZF/SF/CF flags update atomically when the operation completes. It sits as a small-area datapath unit behind a sequencer that issues one operation at a time.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..64.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  request; sampled only while busy=0.
- opcode  in  3  operation; latched with start.
- A  in  WIDTH  operand A; latched with start.
- B  in  WIDTH  operand B; latched with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when C and the flags are updated.
- C  out  WIDTH  result register.
- ZF, SF, CF  out  1 each  zero, sign (C[WIDTH-1]) and carry/borrow flags.
- OF  out  1  signed overflow; present only with SERIAL_ALU_OVF_EN.

## Operation
- Opcodes:
  - 000 CLR
  - 001 NAND
  - 010 ADD
  - 011 OR
  - 100 SUB (A-B)
  - 101 AND
  - 110 XOR
  - 111 ADC (A+B+CF).
- FSM states:
  - IDLE: start=1 latches A, B and opcode into shadow registers, clears the bit index, and goes to RUN. CLR goes to FIN instead.
  - RUN: computes bit i of the shadow result and holds the serial carry in a 1-bit register. After bit WIDTH-1 it goes to FIN.
  - FIN: commits the result to C, commits the flags, drives done=1 for this cycle, then returns to IDLE.
- Serial arithmetic:
  - ADD: carry-in 0.
  - ADC: carry-in is the CF value latched at start.
  - SUB: computed as A + ~B + 1; CF = NOT(final carry), i.e. CF=1 iff A<B unsigned.
  - ADD/ADC: CF = final carry.
- Logic ops (NAND/OR/AND/XOR): CF unchanged.
- Flags:
  - ZF = (result==0); SF = result MSB. Both are updated by every op except CLR.
  - CLR: C=0, ZF=SF=CF=0 (and OF=0).
- C and the flags never show partial results; they change only in FIN.
- start while busy=1: ignored. Operands and opcode are not re-sampled.
- A, B and opcode may change freely after the start cycle.

## Timing
- Reset (rst_n=0 at an edge): state IDLE; busy=0, done=0, C=0, ZF=SF=CF=0, OF=0; shadow registers and carry cleared.
- Reset mid-operation aborts immediately. No done pulse is produced, and the outputs take their reset values.
- start accepted at edge k:
  - busy=1 from after edge k.
  - Bits are computed at edges k+1..k+WIDTH.
  - FIN is entered after edge k+WIDTH. C, the flags and done=1 are visible in cycle k+WIDTH+1.
- Latency start→done = WIDTH+1 cycles for arithmetic and logic ops; CLR = 1 cycle.
- busy is low during the FIN/done cycle. A start presented in that cycle is accepted, so back-to-back throughput is one op per WIDTH+1 cycles.
- When a new start is accepted in the done cycle, ADC uses the CF committed in that same FIN cycle.
- done is exactly one cycle wide; busy and done are never both 1.

## Configuration
- SERIAL_ALU_OVF_EN defined:
  - OF port and logic are present.
  - ADD/ADC/SUB: OF = carry into MSB XOR carry out of MSB, computed on the serial carry chain.
  - Logic ops: OF=0. CLR: OF=0.
- SERIAL_ALU_OVF_EN undefined:
  - No OF port and no overflow logic.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- Reset, then ADD A=0xFF, B=0x01 → done exactly 9 cycles after start; C=0x00, ZF=1, SF=0, CF=1; busy high for 8 cycles.
- SUB A=0x05, B=0x07 → C=0xFE, CF=1, SF=1, ZF=0. Then SUB 0x07−0x05 issued in the done cycle → C=0x02, CF=0, with no idle gap.
- ADD 0xF0+0x20 → C=0x10, CF=1. Then ADC 0x00+0x00 → C=0x01, CF=0. Then NAND 0xFF,0xFF → C=0x00, ZF=1, CF unchanged (0). Then CLR → all flags 0, done after 1 cycle.
- Start ADD 0x11+0x22; pulse start with A=0xFF during busy → ignored, C=0x33. Assert rst_n=0 during cycle 4 of a second op → no done; C=0 and flags=0 next cycle.
- With SERIAL_ALU_OVF_EN:
  - ADD 0x7F+0x01 → C=0x80, OF=1, SF=1.
  - SUB 0x80−0x01 → C=0x7F, OF=1, CF=0.
  - XOR → OF=0.
- C stability: C and the flags must hold their previous values on every cycle of the operation until the done cycle.
